stopwatch_controller: RTL

- Sequencing controller for the 4-digit MM:SS stopwatch datapath. Sits between the debounced button/switch front end and the per-digit BCD-to-cathode decoders feeding segment_display.
- Owns the run/pause/adjust state machine and the BCD minute/second counters. Outputs the four BCD digits plus the registered adj/sel qualifiers that the display uses for blinking.
- All timing comes from single-cycle tick enables in the clk domain. The block creates no clocks.

---
 rtl/stopwatch_controller.sv | 75 +++++++
 1 files changed

// File: rtl/stopwatch_controller.sv
// stopwatch_controller: run/pause/adjust sequencing and BCD MM:SS counters for the stopwatch display
module stopwatch_controller #(
  parameter int MIN_MAX = 59,
  parameter int SEC_MAX = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       pause_pulse,
  input  logic       clr_pulse,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       adj_active,
  output logic       sel_q,
  output logic       running,
  output logic       rollover
);
  typedef enum logic [1:0] {RUN, PAUSE, ADJUST} state_t;

  state_t     state_q, state_d;
  logic [7:0] min_q, min_d, sec_q, sec_d;
  logic [8:0] min_nx, sec_nx;
  logic       run_tick, adj_tick, rollover_d;

  // Two-digit BCD increment; bit 8 flags that the field was at its maximum and wrapped to 00
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input int max);
    logic wrap;
    wrap = v == {4'(max / 10), 4'(max % 10)};
    return wrap ? 9'h100 : (v[3:0] == 4'd9) ? {1'b0, v[7:4] + 4'd1, 4'd0} : {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  assign min_tens = min_q[7:4];
  assign min_ones = min_q[3:0];
  assign sec_tens = sec_q[7:4];
  assign sec_ones = sec_q[3:0];

  // Next count and state: ticks judged against the current state, adj entry suppresses the RUN tick, clear wins over everything
  always_comb begin
    min_nx     = bcd_inc(min_q, MIN_MAX);
    sec_nx     = bcd_inc(sec_q, SEC_MAX);
    run_tick   = (state_q == RUN) && tick_1hz && !adj;
    adj_tick   = (state_q == ADJUST) && tick_2hz;
    sec_d      = clr_pulse ? 8'h00 : (run_tick || (adj_tick && sel_q)) ? sec_nx[7:0] : sec_q;
    min_d      = clr_pulse ? 8'h00 : ((run_tick && sec_nx[8]) || (adj_tick && !sel_q)) ? min_nx[7:0] : min_q;
    rollover_d = run_tick && sec_nx[8] && min_nx[8] && !clr_pulse;
    state_d    = adj ? ADJUST : (state_q == ADJUST) ? PAUSE :
                 pause_pulse ? ((state_q == RUN) ? PAUSE : RUN) : state_q;
  end

  // State, counters and registered display qualifiers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      min_q      <= 8'h00;
      sec_q      <= 8'h00;
      running    <= 1'b1;
      adj_active <= 1'b0;
      sel_q      <= 1'b0;
      rollover   <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      running    <= state_d == RUN;
      adj_active <= state_d == ADJUST;
      sel_q      <= sel;
      rollover   <= rollover_d;
    end
  end
endmodule
